// File: rtl/state_receiver_pkg.sv
// Shared types and constants for the game-state serial link receiver.
package state_receiver_pkg;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
    } location_t;

    typedef struct packed {
        location_t   pos;
        location_t   vel;
        location_t   ball;
        logic [15:0] score;
        logic [9:0]  flags;
    } data_t;

    localparam int STATE_FRAME_WIDTH = $bits(data_t) + 1;

    // Level of the active-low frame select when no frame is in progress.
    localparam logic SEL_IDLE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RECEIVE,
        DRAIN
    } rx_state_e;

endpackage

// File: rtl/state_receiver_if.sv
// Serial link pins from the peer FPGA plus the decoded opponent-state outputs.
interface state_receiver_if;
    import state_receiver_pkg::*;

    logic  data_in;
    logic  data_clk_in;
    logic  sel_in;
    data_t player_data_out;
    logic  player_scored_out;
    logic  data_out_valid;
    logic  frame_error_out;

    modport master (
        output data_in, data_clk_in, sel_in,
        input  player_data_out, player_scored_out, data_out_valid, frame_error_out
    );

    modport slave (
        input  data_in, data_clk_in, sel_in,
        output player_data_out, player_scored_out, data_out_valid, frame_error_out
    );

endinterface

// File: rtl/state_receiver_spi_rx.sv
// Generic MSB-first serial deserializer with input synchronizers, bit-count
// check and stalled-clock timeout. Holds the last good frame on frame_o.
//
// state   | meaning
// IDLE    | waiting for a select falling edge (only once select has been seen high)
// RECEIVE | shifting bits on serial clock rising edges, watching for stall
// DRAIN   | frame aborted by timeout, ignoring edges until select returns high
module state_receiver_spi_rx
    import state_receiver_pkg::*;
#(
    parameter int DATA_WIDTH     = STATE_FRAME_WIDTH,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  data_i,
    input  logic                  data_clk_i,
    input  logic                  sel_i,
    output logic [DATA_WIDTH-1:0] frame_o,
    output logic                  valid_o,
    output logic                  error_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 2);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] BITS_FULL  = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] BITS_SAT   = CNT_W'(DATA_WIDTH + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT  = TMO_W'(TIMEOUT_CYCLES);

    // [0],[1] synchronizer, [2] history; data needs no history stage
    logic [2:0] sel_q;
    logic [2:0] clk_q;
    logic [1:0] dat_q;
    logic [1:0] live_q;
    logic       armed_q;

    logic sel_s, sel_rise, sel_fall, clk_rise, data_s;

    assign sel_s    = sel_q[1];
    assign sel_rise = sel_q[1] & ~sel_q[2];
    assign sel_fall = ~sel_q[1] & sel_q[2];
    assign clk_rise = clk_q[1] & ~clk_q[2];
    assign data_s   = dat_q[1];

    // A select already low at reset release must be seen high before a fall counts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q   <= {3{SEL_IDLE}};
            clk_q   <= '0;
            dat_q   <= '0;
            live_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            sel_q  <= {sel_q[1:0], sel_i};
            clk_q  <= {clk_q[1:0], data_clk_i};
            dat_q  <= {dat_q[0], data_i};
            live_q <= {live_q[0], 1'b1};
            if (live_q[1] && (sel_s == SEL_IDLE)) begin
                armed_q <= 1'b1;
            end
        end
    end

    rx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      bits_q, bits_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] frame_q, frame_d;
    logic                  valid_q, valid_d;
    logic                  error_q, error_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            bits_q  <= '0;
            tmo_q   <= '0;
            shift_q <= '0;
            frame_q <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            tmo_q   <= tmo_d;
            shift_q <= shift_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bits_d  = bits_q;
        tmo_d   = tmo_q;
        shift_d = shift_q;
        frame_d = frame_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_fall && armed_q) begin
                    state_d = RECEIVE;
                    bits_d  = '0;
                    tmo_d   = '0;
                end
            end
            RECEIVE: begin
                // Select release outranks a same-cycle clock edge and the timeout.
                if (sel_rise) begin
                    state_d = IDLE;
                    if (bits_q == BITS_FULL) begin
                        frame_d = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (clk_rise) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], data_s};
                    if (bits_q != BITS_SAT) begin
                        bits_d = bits_q + CNT_W'(1);
                    end
                    tmo_d = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (tmo_d == TMO_LIMIT) begin
                        error_d = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (sel_s == SEL_IDLE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign frame_o = frame_q;
    assign valid_o = valid_q;
    assign error_o = error_q;

endmodule

// File: rtl/state_receiver.sv
// Opponent game-state receiver: deserializes one frame and splits it into the
// player record and the scored flag.
module state_receiver
    import state_receiver_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic      clk_pixel_in,
    input  logic      rst_in,
    state_receiver_if.slave rx
);

    logic [STATE_FRAME_WIDTH-1:0] frame;

    state_receiver_spi_rx #(
        .DATA_WIDTH     (STATE_FRAME_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_spi_rx (
        .clk_i      (clk_pixel_in),
        .rst_i      (rst_in),
        .data_i     (rx.data_in),
        .data_clk_i (rx.data_clk_in),
        .sel_i      (rx.sel_in),
        .frame_o    (frame),
        .valid_o    (rx.data_out_valid),
        .error_o    (rx.frame_error_out)
    );

    assign rx.player_data_out   = data_t'(frame[STATE_FRAME_WIDTH-1:1]);
    assign rx.player_scored_out = frame[0];

endmodule

// File: tb/tb_state_receiver.sv
// Directed bench for state_receiver: table of whole frames plus hand-written
// timeout, mid-frame reset and back-to-back sequences.
module tb_state_receiver;
    import state_receiver_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b1;
    logic dclk = 1'b0;
    logic dat = 1'b0;
    logic tgt = 1'b0;   // 0: main instance, 1: short-timeout instance

    state_receiver_if rx_if();
    state_receiver_if tmo_if();

    assign rx_if.sel_in       = tgt ? 1'b1 : sel;
    assign rx_if.data_clk_in  = tgt ? 1'b0 : dclk;
    assign rx_if.data_in      = tgt ? 1'b0 : dat;
    assign tmo_if.sel_in      = tgt ? sel  : 1'b1;
    assign tmo_if.data_clk_in = tgt ? dclk : 1'b0;
    assign tmo_if.data_in     = tgt ? dat  : 1'b0;

    state_receiver dut (
        .clk_pixel_in (clk),
        .rst_in       (rst),
        .rx           (rx_if.slave)
    );

    state_receiver #(.TIMEOUT_CYCLES(64)) dut_tmo (
        .clk_pixel_in (clk),
        .rst_in       (rst),
        .rx           (tmo_if.slave)
    );

    always #5 clk = ~clk;

    logic        obs_valid, obs_err, obs_scored;
    logic [88:0] obs_data;
    assign obs_valid  = tgt ? tmo_if.data_out_valid    : rx_if.data_out_valid;
    assign obs_err    = tgt ? tmo_if.frame_error_out   : rx_if.frame_error_out;
    assign obs_scored = tgt ? tmo_if.player_scored_out : rx_if.player_scored_out;
    assign obs_data   = tgt ? 89'(tmo_if.player_data_out) : 89'(rx_if.player_data_out);

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int error_cnt = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (obs_valid) valid_cnt++;
        if (obs_err) error_cnt++;
        if ((rx_if.data_out_valid && rx_if.frame_error_out) ||
            (tmo_if.data_out_valid && tmo_if.frame_error_out)) both_cnt++;
    end

    localparam logic [88:0] P1 = 89'h1_5555_5555_5555_5555_5555;
    localparam logic [88:0] P2 = 89'h1_AB_CDEF_0123_4567_89AB_CDEF;
    localparam logic [88:0] P3 = 89'h0_12_3456_789A_BCDE_F012_3456;
    localparam logic [88:0] P4 = 89'h1_FF_0000_FFFF_0000_FFFF_0001;

    typedef struct {
        string       name;
        int          nbits;
        int          hp;
        logic [91:0] bits;
        logic        exp_valid;
        logic [88:0] exp_data;
        logic        exp_scored;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_bits(input int n, input logic [91:0] bits, input int hp);
        for (int i = n - 1; i >= 0; i--) begin
            dat = bits[i];
            repeat (hp) @(negedge clk);
            dclk = 1'b1;
            repeat (hp) @(negedge clk);
            dclk = 1'b0;
        end
    endtask

    task automatic send_frame(input int n, input logic [91:0] bits, input int hp);
        @(negedge clk);
        sel = 1'b0;
        repeat (hp) @(negedge clk);
        pulse_bits(n, bits, hp);
        repeat (hp) @(negedge clk);
        sel = 1'b1;
    endtask

    // Returns the index of the first rising clk edge (after sel rose) with a strobe, 0 if none.
    task automatic observe(output int first_k);
        first_k = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if ((obs_valid || obs_err) && first_k == 0) first_k = k;
        end
    endtask

    task automatic run_frame(input string nm, input int n, input logic [91:0] bits, input int hp,
                             input logic exp_valid, input logic [88:0] exp_data, input logic exp_scored);
        int v0, e0, fk;
        v0 = valid_cnt;
        e0 = error_cnt;
        send_frame(n, bits, hp);
        observe(fk);
        chk({nm, ".strobe_edge"}, fk, 3);
        chk({nm, ".valid_pulses"}, valid_cnt - v0, exp_valid ? 1 : 0);
        chk({nm, ".error_pulses"}, error_cnt - e0, exp_valid ? 0 : 1);
        chk({nm, ".data"}, obs_data, exp_data);
        chk({nm, ".scored"}, obs_scored, exp_scored);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, e0, fk;

        vecs[0] = '{"good_p1",  90, 50, {2'b00, P1, 1'b1}, 1'b1, P1, 1'b1};
        vecs[1] = '{"short89",  89,  6, {3'b000, P3},       1'b0, P1, 1'b1};
        vecs[2] = '{"long91",   91,  6, {1'b0, P4, 2'b10},  1'b0, P1, 1'b1};
        vecs[3] = '{"good_p2",  90,  6, {2'b00, P2, 1'b0}, 1'b1, P2, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset.data", obs_data, 89'h0);
        chk("reset.scored", obs_scored, 1'b0);
        chk("reset.valid", obs_valid, 1'b0);
        chk("reset.error", obs_err, 1'b0);
        repeat (5) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].name, vecs[i].nbits, vecs[i].bits, vecs[i].hp,
                      vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_scored);
        end

        // Timeout on the 64-cycle instance: 10 bits then serial clock stalls high.
        @(negedge clk);
        tgt = 1'b1;
        repeat (4) @(negedge clk);
        v0 = valid_cnt;
        e0 = error_cnt;
        sel = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            dat = i[0];
            repeat (6) @(negedge clk);
            dclk = 1'b1;
            if (i < 9) begin
                repeat (6) @(negedge clk);
                dclk = 1'b0;
            end
        end
        fk = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (obs_err && fk == 0) fk = k;
        end
        chk("timeout.edge", fk, 67);
        chk("timeout.error_pulses", error_cnt - e0, 1);
        @(negedge clk);
        dclk = 1'b0;
        pulse_bits(5, 92'h15, 6);
        chk("timeout.drain_ignored", error_cnt - e0, 1);
        chk("timeout.drain_no_valid", valid_cnt - v0, 0);
        @(negedge clk);
        sel = 1'b1;
        observe(fk);
        chk("timeout.release_silent", fk, 0);
        chk("timeout.held_data", obs_data, 89'h0);
        run_frame("tmo_recover", 90, {2'b00, P3, 1'b1}, 6, 1'b1, P3, 1'b1);
        @(negedge clk);
        tgt = 1'b0;
        repeat (4) @(negedge clk);

        // Reset after bit 40 of a frame on the main instance.
        v0 = valid_cnt;
        e0 = error_cnt;
        sel = 1'b0;
        repeat (6) @(negedge clk);
        pulse_bits(40, {2'b00, P1, 1'b1} >> 50, 6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid.data", obs_data, 89'h0);
        chk("rstmid.scored", obs_scored, 1'b0);
        pulse_bits(50, {2'b00, P1, 1'b1}, 6);
        repeat (6) @(negedge clk);
        sel = 1'b1;
        observe(fk);
        chk("rstmid.no_strobe_edge", fk, 0);
        chk("rstmid.valid_pulses", valid_cnt - v0, 0);
        chk("rstmid.error_pulses", error_cnt - e0, 0);
        chk("rstmid.held_data", obs_data, 89'h0);
        run_frame("rstmid_fresh", 90, {2'b00, P4, 1'b0}, 6, 1'b1, P4, 1'b0);

        // Back-to-back frames with a short select-high gap.
        run_frame("b2b_a", 90, {2'b00, P2, 1'b1}, 5, 1'b1, P2, 1'b1);
        run_frame("b2b_b", 90, {2'b00, P1, 1'b0}, 5, 1'b1, P1, 1'b0);

        chk("never_both_strobes", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
